// File: rtl/mdio_master_if.sv
// Command/response bundle between MAC configuration logic and the MDIO controller.
// Build option MDIO_PREAMBLE_SUPPRESS_EN adds the cmd_no_preamble request field.
interface mdio_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [4:0]  cmd_phy_addr;
  logic [4:0]  cmd_reg_addr;
  logic [15:0] cmd_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        busy;
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
  logic        cmd_no_preamble;
`endif

  modport master (
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    output cmd_no_preamble,
`endif
    output cmd_valid, cmd_write, cmd_phy_addr, cmd_reg_addr, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_rdata, busy
  );

  modport slave (
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    input  cmd_no_preamble,
`endif
    input  cmd_valid, cmd_write, cmd_phy_addr, cmd_reg_addr, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_rdata, busy
  );
endinterface

// File: rtl/mdio_master.sv
// Clause 22 MDIO frame serialiser: one read or write per command, MDC generated from clock_in.
// Build option MDIO_PREAMBLE_SUPPRESS_EN allows a command to skip the preamble.
module mdio_master #(
  parameter int unsigned MDC_DIVIDER   = 20,
  parameter int unsigned PREAMBLE_BITS = 32
) (
  input  logic         clock_in,
  input  logic         reset,
  mdio_master_if.slave cmd_if,
  output logic         mdc,
  output logic         mdio_o,
  output logic         mdio_oe,
  input  logic         mdio_i
);

  localparam int unsigned BitMax = (PREAMBLE_BITS > 16) ? PREAMBLE_BITS : 16;
  localparam int unsigned BitW   = $clog2(BitMax);
  localparam int unsigned DivW   = $clog2(MDC_DIVIDER);

  localparam logic [DivW-1:0] DivLast = DivW'(MDC_DIVIDER - 1);
  localparam logic [BitW-1:0] PreLast = BitW'(PREAMBLE_BITS - 1);

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StPreamble = 3'd1;
  localparam logic [2:0] StHeader   = 3'd2;
  localparam logic [2:0] StTa       = 3'd3;
  localparam logic [2:0] StData     = 3'd4;
  localparam logic [2:0] StDone     = 3'd5;

  logic [2:0]      state_q, state_d;
  logic [DivW-1:0] div_q, div_d;
  logic [BitW-1:0] bit_q, bit_d;
  logic            mdc_q, mdc_d;
  logic            write_q, write_d;
  logic [4:0]      phy_q, phy_d;
  logic [4:0]      reg_q, reg_d;
  logic [15:0]     wdata_q, wdata_d;
  logic [15:0]     shift_q, shift_d;
  logic [15:0]     rdata_q, rdata_d;
  logic            mdio_o_q, mdio_o_d;
  logic            oe_q, oe_d;
  logic            div_end, bit_last, no_pre;
  logic [13:0]     hdr;

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
  assign no_pre = cmd_if.cmd_no_preamble;
`else
  assign no_pre = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    bit_d    = bit_q;
    mdc_d    = mdc_q;
    write_d  = write_q;
    phy_d    = phy_q;
    reg_d    = reg_q;
    wdata_d  = wdata_q;
    shift_d  = shift_q;
    rdata_d  = rdata_q;
    div_end  = 1'b0;
    bit_last = 1'b0;
    case (state_q)
      StIdle: begin
        if (cmd_if.cmd_valid) begin
          write_d = cmd_if.cmd_write;
          phy_d   = cmd_if.cmd_phy_addr;
          reg_d   = cmd_if.cmd_reg_addr;
          wdata_d = cmd_if.cmd_wdata;
          div_d   = '0;
          bit_d   = '0;
          mdc_d   = 1'b0;
          state_d = (no_pre || PREAMBLE_BITS == 0) ? StHeader : StPreamble;
        end
      end
      StDone: state_d = StIdle;
      default: begin
        div_end = (div_q == DivLast);
        div_d   = div_end ? '0 : div_q + 1'b1;
        if (div_end) mdc_d = ~mdc_q;
        // Read data is captured on the cycle mdc rises.
        if (div_end && !mdc_q && state_q == StData && !write_q) begin
          shift_d = {shift_q[14:0], mdio_i};
        end
        if (div_end && mdc_q) begin
          case (state_q)
            StPreamble: bit_last = (bit_q == PreLast);
            StHeader:   bit_last = (bit_q == BitW'(13));
            StTa:       bit_last = (bit_q == BitW'(1));
            default:    bit_last = (bit_q == BitW'(15));
          endcase
          if (bit_last) begin
            bit_d = '0;
            case (state_q)
              StPreamble: state_d = StHeader;
              StHeader:   state_d = StTa;
              StTa:       state_d = StData;
              default: begin
                state_d = StDone;
                if (!write_q) rdata_d = shift_q;
              end
            endcase
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
    endcase

    // Pin values follow the next bit position, so they only move on accept or falling mdc.
    hdr      = {2'b01, (write_d ? 2'b01 : 2'b10), phy_d, reg_d};
    mdio_o_d = 1'b1;
    oe_d     = 1'b0;
    case (state_d)
      StPreamble: oe_d = 1'b1;
      StHeader: begin
        oe_d     = 1'b1;
        mdio_o_d = hdr[4'd13 - bit_d[3:0]];
      end
      StTa: begin
        oe_d     = write_d;
        mdio_o_d = write_d ? (bit_d == '0) : 1'b1;
      end
      StData: begin
        oe_d     = write_d;
        mdio_o_d = write_d ? wdata_d[4'd15 - bit_d[3:0]] : 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock_in) begin
    if (reset) begin
      state_q  <= StIdle;
      div_q    <= '0;
      bit_q    <= '0;
      mdc_q    <= 1'b0;
      write_q  <= 1'b0;
      phy_q    <= '0;
      reg_q    <= '0;
      wdata_q  <= '0;
      shift_q  <= '0;
      rdata_q  <= '0;
      mdio_o_q <= 1'b1;
      oe_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      mdc_q    <= mdc_d;
      write_q  <= write_d;
      phy_q    <= phy_d;
      reg_q    <= reg_d;
      wdata_q  <= wdata_d;
      shift_q  <= shift_d;
      rdata_q  <= rdata_d;
      mdio_o_q <= mdio_o_d;
      oe_q     <= oe_d;
    end
  end

  assign cmd_if.cmd_ready = (state_q == StIdle);
  assign cmd_if.busy      = (state_q != StIdle);
  assign cmd_if.rsp_valid = (state_q == StDone);
  assign cmd_if.rsp_rdata = rdata_q;
  assign mdc              = mdc_q;
  assign mdio_o           = mdio_o_q;
  assign mdio_oe          = oe_q;

endmodule

// File: tb/tb_mdio_master.sv
// Randomised bench for mdio_master: frame-level reference model, PHY read model and MDC timing monitor.
module tb_mdio_master;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;

  mdio_master_if if_a ();
  mdio_master_if if_b ();
  logic mdc_a, mdio_o_a, oe_a;
  logic mdio_i_a = 1'b1;
  logic mdc_b, mdio_o_b, oe_b;
  logic mdio_i_b = 1'b1;

  mdio_master #(.MDC_DIVIDER(2), .PREAMBLE_BITS(32)) dut (
    .clock_in(clk), .reset(rst), .cmd_if(if_a),
    .mdc(mdc_a), .mdio_o(mdio_o_a), .mdio_oe(oe_a), .mdio_i(mdio_i_a)
  );
  mdio_master #(.MDC_DIVIDER(5), .PREAMBLE_BITS(32)) dut5 (
    .clock_in(clk), .reset(rst), .cmd_if(if_b),
    .mdc(mdc_b), .mdio_o(mdio_o_b), .mdio_oe(oe_b), .mdio_i(mdio_i_b)
  );

  // Reference model: expected pin values per frame bit, captured pin values at each rising mdc.
  bit exp_o[$], exp_oe[$], cap_o[$], cap_oe[$];
  logic [15:0] cur_rd = '0;
  int cur_pre = 32;
  logic [15:0] model_rdata = '0;

  function automatic void build_frame(bit wr, logic [4:0] phy, logic [4:0] ra, logic [15:0] wd,
                                      bit nopre);
    exp_o.delete();
    exp_oe.delete();
    if (!nopre) repeat (32) begin exp_o.push_back(1); exp_oe.push_back(1); end
    exp_o.push_back(0); exp_oe.push_back(1);
    exp_o.push_back(1); exp_oe.push_back(1);
    exp_o.push_back(!wr); exp_oe.push_back(1);
    exp_o.push_back(wr);  exp_oe.push_back(1);
    for (int i = 4; i >= 0; i--) begin exp_o.push_back(phy[i]); exp_oe.push_back(1); end
    for (int i = 4; i >= 0; i--) begin exp_o.push_back(ra[i]); exp_oe.push_back(1); end
    exp_o.push_back(1); exp_oe.push_back(wr);
    exp_o.push_back(0); exp_oe.push_back(wr);
    for (int i = 15; i >= 0; i--) begin exp_o.push_back(wr ? wd[i] : 1'b1); exp_oe.push_back(wr); end
  endfunction

  function automatic logic phy_bit(int k);
    int d;
    d = k - cur_pre - 16;
    if (d >= 0 && d < 16) return cur_rd[15-d];
    return 1'b1;
  endfunction

  // Monitor + PHY for dut: PHY presents the next bit right after mdc falls.
  logic mdc_a_prev = 1'b0;
  always @(negedge clk) begin
    if (mdc_a && !mdc_a_prev) begin
      cap_o.push_back(mdio_o_a);
      cap_oe.push_back(oe_a);
    end
    if (!mdc_a && mdc_a_prev) mdio_i_a = phy_bit(cap_o.size());
    mdc_a_prev = mdc_a;
  end

  // MDC period / data stability monitor for dut5.
  logic mdc_b_prev = 1'b0, mdio_o_b_prev = 1'b1;
  int run_b = 0, bad_period = 0, bad_stable = 0, rises_b = 0;
  bit seen_fall_b = 0;
  always @(negedge clk) begin
    if (!if_b.busy) seen_fall_b = 0;
    if (mdc_b != mdc_b_prev) begin
      if (mdc_b) begin
        if (seen_fall_b && run_b != 5) bad_period++;
        if (mdio_o_b != mdio_o_b_prev) bad_stable++;
        rises_b++;
      end else begin
        if (run_b != 5) bad_period++;
        seen_fall_b = 1;
      end
      run_b = 1;
    end else begin
      run_b++;
    end
    mdc_b_prev    = mdc_b;
    mdio_o_b_prev = mdio_o_b;
  end

  task automatic start_cmd(input bit wr, input logic [4:0] phy, input logic [4:0] ra,
                           input logic [15:0] wd, input logic [15:0] rd, input bit nopre,
                           input bit hold, output int acc);
    int t;
    if_a.cmd_valid    = 1'b1;
    if_a.cmd_write    = wr;
    if_a.cmd_phy_addr = phy;
    if_a.cmd_reg_addr = ra;
    if_a.cmd_wdata    = wd;
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    if_a.cmd_no_preamble = nopre;
`endif
    for (t = 0; t < 3000 && !if_a.cmd_ready; t++) @(negedge clk);
    checks++;
    if (!if_a.cmd_ready) $display("FAIL accept_timeout: cmd_ready=%0b after %0d cycles, required 1",
                                  if_a.cmd_ready, t);
    else passes++;
    acc = cyc;
    cur_rd  = rd;
    cur_pre = nopre ? 0 : 32;
    cap_o.delete();
    cap_oe.delete();
    build_frame(wr, phy, ra, wd, nopre);
    if (!hold) begin
      @(negedge clk);
      if_a.cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_rsp(output int rc);
    rc = -1;
    for (int t = 0; t < 5000; t++) begin
      if (if_a.rsp_valid) begin rc = cyc; break; end
      @(negedge clk);
    end
    checks++;
    if (rc < 0) $display("FAIL rsp_timeout: rsp_valid never seen, required within 5000 cycles");
    else passes++;
  endtask

  task automatic check_frame(input string name, input int acc, input int rc);
    int n, o_bad, oe_bad;
    n = exp_o.size();
    o_bad = 0;
    oe_bad = 0;
    for (int i = 0; i < n && i < cap_o.size(); i++) begin
      if (cap_oe[i] !== exp_oe[i]) oe_bad++;
      if (exp_oe[i] && cap_o[i] !== exp_o[i]) o_bad++;
    end
    checks++;
    if (rc - acc !== 1 + n * 4)
      $display("FAIL %s latency: got %0d, required %0d", name, rc - acc, 1 + n * 4);
    else passes++;
    checks++;
    if (cap_o.size() !== n)
      $display("FAIL %s bit_count: got %0d, required %0d", name, cap_o.size(), n);
    else passes++;
    checks++;
    if (o_bad !== 0) $display("FAIL %s mdio_o: %0d wrong bits, required 0", name, o_bad);
    else passes++;
    checks++;
    if (oe_bad !== 0) $display("FAIL %s mdio_oe: %0d wrong bits, required 0", name, oe_bad);
    else passes++;
    checks++;
    if (if_a.rsp_rdata !== model_rdata)
      $display("FAIL %s rsp_rdata: got %h, required %h", name, if_a.rsp_rdata, model_rdata);
    else passes++;
    @(negedge clk);
    checks++;
    if (if_a.rsp_valid !== 1'b0 || if_a.cmd_ready !== 1'b1)
      $display("FAIL %s after_done: rsp_valid=%0b cmd_ready=%0b, required 0 and 1", name,
               if_a.rsp_valid, if_a.cmd_ready);
    else passes++;
  endtask

  task automatic do_frame(input string name, input bit wr, input logic [4:0] phy,
                          input logic [4:0] ra, input logic [15:0] wd, input logic [15:0] rd,
                          input bit nopre);
    int acc, rc;
    start_cmd(wr, phy, ra, wd, rd, nopre, 1'b0, acc);
    wait_rsp(rc);
    if (!wr) model_rdata = rd;
    check_frame(name, acc, rc);
  endtask

  task automatic test_reset;
    checks++;
    if (if_a.cmd_ready !== 1'b1 || if_a.busy !== 1'b0)
      $display("FAIL reset_handshake: ready=%0b busy=%0b, required 1 and 0", if_a.cmd_ready, if_a.busy);
    else passes++;
    checks++;
    if (if_a.rsp_valid !== 1'b0 || if_a.rsp_rdata !== 16'h0)
      $display("FAIL reset_rsp: valid=%0b rdata=%h, required 0 and 0000", if_a.rsp_valid,
               if_a.rsp_rdata);
    else passes++;
    checks++;
    if (mdc_a !== 1'b0 || mdio_o_a !== 1'b1 || oe_a !== 1'b0)
      $display("FAIL reset_pins: mdc=%0b mdio_o=%0b oe=%0b, required 0 1 0", mdc_a, mdio_o_a, oe_a);
    else passes++;
  endtask

  task automatic test_write;
    do_frame("write_1140", 1'b1, 5'h01, 5'h00, 16'h1140, 16'h0, 1'b0);
  endtask

  task automatic test_read;
    do_frame("read_0141", 1'b0, 5'h03, 5'h02, 16'h0, 16'h0141, 1'b0);
  endtask

  task automatic test_random;
    for (int i = 0; i < 4; i++) begin
      do_frame($sformatf("random%0d", i), 1'($urandom), 5'($urandom), 5'($urandom),
               16'($urandom), 16'($urandom), 1'b0);
    end
  endtask

  task automatic test_back_to_back;
    int a1, rc1, a2, rc2;
    logic [15:0] rd1, wd2;
    rd1 = 16'($urandom);
    wd2 = 16'($urandom);
    start_cmd(1'b0, 5'($urandom), 5'($urandom), 16'h0, rd1, 1'b0, 1'b1, a1);
    @(negedge clk);
    if_a.cmd_write    = 1'b1;
    if_a.cmd_phy_addr = 5'h1a;
    if_a.cmd_reg_addr = 5'h05;
    if_a.cmd_wdata    = wd2;
    repeat (100) @(negedge clk);
    checks++;
    if (if_a.cmd_ready !== 1'b0 || if_a.busy !== 1'b1)
      $display("FAIL b2b_busy: ready=%0b busy=%0b, required 0 and 1", if_a.cmd_ready, if_a.busy);
    else passes++;
    wait_rsp(rc1);
    model_rdata = rd1;
    check_frame("b2b_first", a1, rc1);
    start_cmd(1'b1, 5'h1a, 5'h05, wd2, 16'h0, 1'b0, 1'b0, a2);
    checks++;
    if (a2 !== rc1 + 1) $display("FAIL b2b_accept: accept cycle %0d, required %0d", a2, rc1 + 1);
    else passes++;
    wait_rsp(rc2);
    check_frame("b2b_second", a2, rc2);
  endtask

  task automatic test_reset_abort;
    int acc, pulses;
    start_cmd(1'b0, 5'($urandom), 5'($urandom), 16'h0, 16'($urandom), 1'b0, 1'b0, acc);
    repeat (39) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (mdc_a !== 1'b0 || oe_a !== 1'b0 || if_a.cmd_ready !== 1'b1)
      $display("FAIL abort_pins: mdc=%0b oe=%0b ready=%0b, required 0 0 1", mdc_a, oe_a,
               if_a.cmd_ready);
    else passes++;
    model_rdata = 16'h0;
    pulses = 0;
    repeat (400) begin
      @(negedge clk);
      if (if_a.rsp_valid) pulses++;
    end
    checks++;
    if (pulses !== 0) $display("FAIL abort_rsp: %0d rsp_valid pulses, required 0", pulses);
    else passes++;
    do_frame("after_abort", 1'b1, 5'($urandom), 5'($urandom), 16'($urandom), 16'h0, 1'b0);
  endtask

  task automatic test_mdc_timing;
    int t, acc, rc;
    if_b.cmd_valid    = 1'b1;
    if_b.cmd_write    = 1'b1;
    if_b.cmd_phy_addr = 5'($urandom);
    if_b.cmd_reg_addr = 5'($urandom);
    if_b.cmd_wdata    = 16'($urandom);
    for (t = 0; t < 100 && !if_b.cmd_ready; t++) @(negedge clk);
    acc = cyc;
    rises_b = 0;
    bad_period = 0;
    bad_stable = 0;
    @(negedge clk);
    if_b.cmd_valid = 1'b0;
    rc = -1;
    for (t = 0; t < 3000; t++) begin
      if (if_b.rsp_valid) begin rc = cyc; break; end
      @(negedge clk);
    end
    checks++;
    if (rc - acc !== 641) $display("FAIL div5_latency: got %0d, required 641", rc - acc);
    else passes++;
    checks++;
    if (rises_b !== 64) $display("FAIL div5_rises: got %0d, required 64", rises_b);
    else passes++;
    checks++;
    if (bad_period !== 0) $display("FAIL div5_period: %0d bad half-periods, required 0", bad_period);
    else passes++;
    checks++;
    if (bad_stable !== 0)
      $display("FAIL div5_stability: %0d changes on rising mdc, required 0", bad_stable);
    else passes++;
    @(negedge clk);
  endtask

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
  task automatic test_no_preamble;
    do_frame("no_preamble_wr", 1'b1, 5'($urandom), 5'($urandom), 16'($urandom), 16'h0, 1'b1);
    checks++;
    if (cap_o.size() == 0 || cap_o[0] !== 1'b0)
      $display("FAIL no_preamble_st: first bit %0b (count %0d), required 0", cap_o.size() ? cap_o[0] : 1'b1,
               cap_o.size());
    else passes++;
    do_frame("no_preamble_rd", 1'b0, 5'($urandom), 5'($urandom), 16'h0, 16'($urandom), 1'b1);
  endtask
`endif

  initial begin
    if_a.cmd_valid = 1'b0; if_a.cmd_write = 1'b0; if_a.cmd_phy_addr = '0;
    if_a.cmd_reg_addr = '0; if_a.cmd_wdata = '0;
    if_b.cmd_valid = 1'b0; if_b.cmd_write = 1'b0; if_b.cmd_phy_addr = '0;
    if_b.cmd_reg_addr = '0; if_b.cmd_wdata = '0;
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    if_a.cmd_no_preamble = 1'b0;
    if_b.cmd_no_preamble = 1'b0;
`endif
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_write();
    test_read();
    test_random();
    test_back_to_back();
    test_reset_abort();
    test_mdc_timing();
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    test_no_preamble();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
